phase_delta_avg: RTL and testbench
==================================

# phase_delta_avg

Per-sample phase-increment estimator placed directly downstream of the `phase` stage in the OFDM receive chain. It consumes the strobed phase stream (radians scaled by 512, range [-PI, PI)) and forms wrapped successive differences. It outputs their moving average over 2^AVG_SHIFT samples as a carrier-frequency-offset estimate, together with a running unwrapped phase.

## Interface
- AVG_SHIFT, 4, log2 of the averaging window; window W = 2^AVG_SHIFT, legal range 1..6.
- clock  in  1  single clock domain; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  global advance; low freezes every register.
- clear  in  1  synchronous restart of estimation; state is identical to after reset.
- phase_in  in  32  signed phase from the upstream phase stage, scaled by 512.
- input_strobe  in  1  phase_in valid this cycle.
- freq_out  out  32  signed windowed mean of wrapped phase deltas, in phase units per sample.
- phase_unwrapped  out  32  signed running unwrapped phase; wraps modulo 2^32.
- freq_valid  out  1  freq_out is the mean over a full window.
- output_strobe  out  1  one-cycle pulse; freq_out, phase_unwrapped and freq_valid are updated.

## Operation
- Constants: PI = 1608, DOUBLE_PI = 3217.
- Stage 1, on `input_strobe & enable`:
  - First sample after reset or clear (primed = 0): store prev = phase_in, set unwrapped = phase_in, set primed = 1. Produce no output.
  - Otherwise: delta_raw = phase_in - prev (33-bit signed), then prev <= phase_in.
- Stage 2, wrap:
  - delta_raw >= PI: delta = delta_raw - DOUBLE_PI.
  - delta_raw < -PI: delta = delta_raw + DOUBLE_PI.
  - Otherwise delta = delta_raw.
  - Result is in [-PI, PI) and fits in 12 bits signed, carried as 32.
- Stage 3, accumulate:
  - sum <= sum + delta - ring[wr_ptr].
  - ring[wr_ptr] <= delta; wr_ptr <= wr_ptr + 1 modulo W.
  - count <= min(count + 1, W).
  - unwrapped <= unwrapped + delta.
- Output register:
  - freq_out = new sum >>> AVG_SHIFT (arithmetic shift, floor).
  - phase_unwrapped = new unwrapped.
  - freq_valid = (new count == W).
  - output_strobe = 1.
- sum is 32-bit signed; |sum| <= 1608·64, so it cannot overflow.
- Ring contents are zeroed on reset and clear. Before the window fills, subtracting ring[wr_ptr] subtracts 0, so sum is the partial sum.
- clear and input_strobe in the same cycle: clear wins, the sample is dropped, and in-flight stage valids are cancelled.
- enable low:
  - All state, including stage valid bits, holds.
  - output_strobe is driven 0.
  - In-flight samples resume when enable returns; no sample is lost or duplicated.
- Back-to-back strobes every cycle are supported at full throughput.

## Timing
- Latency: input_strobe at cycle t, with enable held high, gives output_strobe at t+3.
- Reset values: freq_out = 0, phase_unwrapped = 0, freq_valid = 0, output_strobe = 0. Internal prev, sum, count, wr_ptr, primed and ring all = 0.
- reset asserted mid-pipeline: in-flight samples are discarded and no output_strobe is produced for them.
- clear timing: first output after clear comes from the second post-clear sample. freq_valid first asserts on the output of the (W+1)-th post-clear sample.
- freq_out, phase_unwrapped and freq_valid hold their values between strobes.

## Structure
- PI and DOUBLE_PI come from the shared `common_params.v`. Add AVG-window defaults to `common_defs.v` if other stages need them.
- Sub-module `delta_ring`: W-entry × 32-bit circular buffer.
  - Write port plus read-before-write at wr_ptr.
  - Synchronous zero-fill on clear; asynchronous clear on reset.
  - Registered pointer.
- Top-level logic: wrap pipeline, accumulator, valid shift chain, output registers.

## Test plan
- Linear ramp phase_in = 0, 100, 200, …, 1600 (17 strobes, one per cycle):
  - 16 output_strobes, the first 3 cycles after the second input.
  - freq_out = 100 when freq_valid rises on the 16th output.
  - phase_unwrapped = 1600 at the last output.
- Wrap-around, phase_in = 1500 then -1500:
  - delta = -3000 + 3217 = 217.
  - phase_unwrapped = 1717.
  - freq_out = 217 >>> 4 = 13, freq_valid = 0.
- Negative floor, constant delta -3 for 20 samples: freq_out = -3 with freq_valid = 1 after 16 deltas. Then deltas of -1 give freq_out = -1 once the window is flushed.
- Strobe with enable toggling low for 5 cycles mid-stream:
  - Output count and values are identical to the uninterrupted run.
  - output_strobe is 0 while enable is low.
- clear asserted together with a strobe after 10 samples:
  - That sample is dropped; freq_valid = 0.
  - Next output appears only after two new samples.
  - freq_out equals that single post-clear delta >>> 4.
- Asynchronous reset pulsed mid-window, between clock edges:
  - All outputs are 0 immediately.
  - No output_strobe appears for pre-reset samples.

Source files
------------

// File: rtl/phase_delta_avg_pkg.sv
// Shared constants and the phase-delta wrap helper for phase_delta_avg.
package phase_delta_avg_pkg;

  // Phase scale is radians * 512; deltas are formed at 33 bits before wrapping.
  localparam logic signed [32:0] PI        = 33'sd1608;
  localparam logic signed [32:0] DOUBLE_PI = 33'sd3217;

  // Fold a raw successive difference back into [-PI, PI).
  function automatic logic signed [31:0] wrap_delta(input logic signed [32:0] raw);
    logic signed [32:0] w;
    w = raw;
    if (raw >= PI) begin
      w = raw - DOUBLE_PI;
    end else if (raw < -PI) begin
      w = raw + DOUBLE_PI;
    end else begin
      w = raw;
    end
    return w[31:0];
  endfunction

endpackage

// File: rtl/phase_delta_avg_ring.sv
// delta_ring: circular buffer of the last 2^DEPTH_LOG2 wrapped deltas.
// The entry at the write pointer is read combinationally (the oldest delta)
// and overwritten on the same edge, giving read-before-write semantics.
module delta_ring #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               write,
  input  logic signed [31:0] wdata,
  output logic signed [31:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic signed [31:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;

  assign rdata = mem[wr_ptr];

  // Storage and pointer: zero-filled on reset or clear, advance on each write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'sd0;
    end else if (clear) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'sd0;
    end else if (write) begin
      mem[wr_ptr] <= wdata;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/phase_delta_avg.sv
// phase_delta_avg: wrapped phase-increment moving average (CFO estimate)
// plus running unwrapped phase. Three-stage pipeline: difference, wrap,
// accumulate/output. enable freezes everything; clear restarts estimation.
module phase_delta_avg
  import phase_delta_avg_pkg::*;
#(
  parameter int AVG_SHIFT = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic signed [31:0] phase_in,
  input  logic               input_strobe,
  output logic signed [31:0] freq_out,
  output logic signed [31:0] phase_unwrapped,
  output logic               freq_valid,
  output logic               output_strobe
);

  localparam int W  = 1 << AVG_SHIFT;
  localparam int CW = AVG_SHIFT + 1;

  logic               primed;
  logic signed [31:0] prev;
  logic               s1_valid;
  logic signed [32:0] delta_raw;
  logic               s2_valid;
  logic signed [31:0] delta;
  logic signed [31:0] sum;
  logic signed [31:0] unwrapped;
  logic [CW-1:0]      count;
  logic               strobe_q;
  logic signed [31:0] ring_rd;
  logic               load_first;
  logic signed [31:0] sum_next;
  logic signed [31:0] unwrapped_next;
  logic [CW-1:0]      count_next;

  // The very first sample only seeds prev and the unwrapped phase.
  assign load_first = enable & input_strobe & ~primed;

  delta_ring #(.DEPTH_LOG2(AVG_SHIFT)) u_ring (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .write (enable & s2_valid),
    .wdata (delta),
    .rdata (ring_rd)
  );

  // Stage 1: capture the raw 33-bit difference against the previous sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      primed    <= 1'b0;
      prev      <= 32'sd0;
      s1_valid  <= 1'b0;
      delta_raw <= 33'sd0;
    end else if (clear) begin
      primed    <= 1'b0;
      prev      <= 32'sd0;
      s1_valid  <= 1'b0;
      delta_raw <= 33'sd0;
    end else if (enable) begin
      s1_valid <= 1'b0;
      if (input_strobe) begin
        prev <= phase_in;
        if (primed) begin
          delta_raw <= {phase_in[31], phase_in} - {prev[31], prev};
          s1_valid  <= 1'b1;
        end else begin
          primed <= 1'b1;
        end
      end
    end
  end

  // Stage 2: wrap the difference into [-PI, PI).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      delta    <= 32'sd0;
    end else if (clear) begin
      s2_valid <= 1'b0;
      delta    <= 32'sd0;
    end else if (enable) begin
      s2_valid <= s1_valid;
      delta    <= wrap_delta(delta_raw);
    end
  end

  // Stage 3 next-state: window sum drops the oldest delta, count saturates at W.
  always_comb begin
    sum_next       = sum + delta - ring_rd;
    unwrapped_next = unwrapped + delta;
    count_next     = count;
    if (count == CW'(W)) begin
      count_next = count;
    end else begin
      count_next = count + 1'b1;
    end
  end

  // Stage 3 and output registers; outputs hold between strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum             <= 32'sd0;
      unwrapped       <= 32'sd0;
      count           <= '0;
      strobe_q        <= 1'b0;
      freq_out        <= 32'sd0;
      phase_unwrapped <= 32'sd0;
      freq_valid      <= 1'b0;
    end else if (clear) begin
      sum             <= 32'sd0;
      unwrapped       <= 32'sd0;
      count           <= '0;
      strobe_q        <= 1'b0;
      freq_out        <= 32'sd0;
      phase_unwrapped <= 32'sd0;
      freq_valid      <= 1'b0;
    end else if (enable) begin
      strobe_q <= s2_valid;
      if (load_first) begin
        unwrapped <= phase_in;
      end else if (s2_valid) begin
        unwrapped <= unwrapped_next;
      end
      if (s2_valid) begin
        sum             <= sum_next;
        count           <= count_next;
        freq_out        <= sum_next >>> AVG_SHIFT;
        phase_unwrapped <= unwrapped_next;
        freq_valid      <= (count_next == CW'(W));
      end
    end
  end

  // A pending strobe is frozen with the pipeline and presented once enable returns.
  assign output_strobe = strobe_q & enable;

endmodule

// File: tb/tb_phase_delta_avg.sv
// Directed self-checking bench for phase_delta_avg (AVG_SHIFT = 4, W = 16).
module tb_phase_delta_avg;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic               clear;
  logic               input_strobe;
  logic signed [31:0] phase_in;
  logic signed [31:0] freq_out;
  logic signed [31:0] phase_unwrapped;
  logic               freq_valid;
  logic               output_strobe;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int q_freq[$];
  int q_unw[$];
  int q_val[$];
  int q_cyc[$];

  phase_delta_avg #(.AVG_SHIFT(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .clear           (clear),
    .phase_in        (phase_in),
    .input_strobe    (input_strobe),
    .freq_out        (freq_out),
    .phase_unwrapped (phase_unwrapped),
    .freq_valid      (freq_valid),
    .output_strobe   (output_strobe)
  );

  always #5 clock = ~clock;

  // Cycle counter for latency measurement.
  always @(posedge clock) cyc <= cyc + 1;

  // Record every output strobe, sampled mid-cycle.
  always @(negedge clock) begin
    if (output_strobe === 1'b1) begin
      q_freq.push_back(int'(freq_out));
      q_unw.push_back(int'(phase_unwrapped));
      q_val.push_back(int'(freq_valid));
      q_cyc.push_back(cyc);
    end
  end

  task automatic send(input int p);
    phase_in     = p;
    input_strobe = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    input_strobe = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic flush();
    q_freq.delete(); q_unw.delete(); q_val.delete(); q_cyc.delete();
  endtask

  task automatic do_clear();
    input_strobe = 1'b0;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (freq_out !== 32'sd0 || phase_unwrapped !== 32'sd0 || freq_valid !== 1'b0 || output_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got freq=%0d unw=%0d valid=%b strobe=%b want 0 0 0 0",
               freq_out, phase_unwrapped, freq_valid, output_strobe);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    idle(2);
    checks++;
    if (output_strobe !== 1'b0 || freq_out !== 32'sd0) begin
      errors++;
      $display("FAIL post_reset_idle got strobe=%b freq=%0d want 0 0", output_strobe, freq_out);
    end
  endtask

  task automatic test_ramp();
    int t2;
    do_clear(); flush();
    t2 = 0;
    for (int k = 0; k < 17; k++) begin
      if (k == 1) t2 = cyc;
      send(100 * k);
    end
    idle(6);
    checks++;
    if (q_freq.size() !== 16) begin
      errors++;
      $display("FAIL ramp_count got %0d want 16", q_freq.size());
    end
    checks++;
    if (q_cyc.size() < 1 || q_cyc[0] !== t2 + 3) begin
      errors++;
      $display("FAIL ramp_latency got cycle %0d want %0d", (q_cyc.size() > 0) ? q_cyc[0] : -1, t2 + 3);
    end
    for (int k = 0; k < 16 && k < q_freq.size(); k++) begin
      checks++;
      if (q_freq[k] !== (100 * (k + 1)) / 16 || q_unw[k] !== 100 * (k + 1) || q_val[k] !== ((k == 15) ? 1 : 0)) begin
        errors++;
        $display("FAIL ramp_out[%0d] got freq=%0d unw=%0d valid=%0d want %0d %0d %0d", k,
                 q_freq[k], q_unw[k], q_val[k], (100 * (k + 1)) / 16, 100 * (k + 1), (k == 15) ? 1 : 0);
      end
    end
  endtask

  task automatic test_wrap();
    do_clear(); flush();
    send(1500);
    send(-1500);
    idle(6);
    checks++;
    if (q_freq.size() !== 1 || q_freq[0] !== 13 || q_unw[0] !== 1717 || q_val[0] !== 0) begin
      errors++;
      $display("FAIL wrap got n=%0d freq=%0d unw=%0d valid=%0d want 1 13 1717 0",
               q_freq.size(), q_freq[0], q_unw[0], q_val[0]);
    end
  endtask

  task automatic test_negative_floor();
    do_clear(); flush();
    for (int k = 0; k <= 20; k++) send(-3 * k);
    for (int k = 1; k <= 16; k++) send(-60 - k);
    idle(6);
    checks++;
    if (q_freq.size() !== 36) begin
      errors++;
      $display("FAIL neg_count got %0d want 36", q_freq.size());
    end else begin
      checks++;
      if (q_freq[0] !== -1 || q_val[0] !== 0) begin
        errors++;
        $display("FAIL neg_first got freq=%0d valid=%0d want -1 0", q_freq[0], q_val[0]);
      end
      checks++;
      if (q_freq[14] !== -3 || q_val[14] !== 0) begin
        errors++;
        $display("FAIL neg_partial got freq=%0d valid=%0d want -3 0", q_freq[14], q_val[14]);
      end
      checks++;
      if (q_freq[15] !== -3 || q_val[15] !== 1 || q_freq[19] !== -3 || q_unw[19] !== -60) begin
        errors++;
        $display("FAIL neg_full got freq15=%0d valid15=%0d freq19=%0d unw19=%0d want -3 1 -3 -60",
                 q_freq[15], q_val[15], q_freq[19], q_unw[19]);
      end
      checks++;
      if (q_freq[27] !== -2) begin
        errors++;
        $display("FAIL neg_mixed got %0d want -2", q_freq[27]);
      end
      checks++;
      if (q_freq[35] !== -1 || q_val[35] !== 1 || q_unw[35] !== -76) begin
        errors++;
        $display("FAIL neg_flushed got freq=%0d valid=%0d unw=%0d want -1 1 -76",
                 q_freq[35], q_val[35], q_unw[35]);
      end
    end
  endtask

  task automatic test_enable_gap();
    do_clear(); flush();
    for (int k = 0; k < 9; k++) send(100 * k);
    enable       = 1'b0;
    phase_in     = 900;
    input_strobe = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #4;
      checks++;
      if (output_strobe !== 1'b0) begin
        errors++;
        $display("FAIL gap_strobe[%0d] got %b want 0", c, output_strobe);
      end
      @(posedge clock); #1;
    end
    enable = 1'b1;
    for (int k = 9; k < 17; k++) send(100 * k);
    idle(6);
    checks++;
    if (q_freq.size() !== 16) begin
      errors++;
      $display("FAIL gap_count got %0d want 16", q_freq.size());
    end
    for (int k = 0; k < 16 && k < q_freq.size(); k++) begin
      checks++;
      if (q_freq[k] !== (100 * (k + 1)) / 16 || q_unw[k] !== 100 * (k + 1) || q_val[k] !== ((k == 15) ? 1 : 0)) begin
        errors++;
        $display("FAIL gap_out[%0d] got freq=%0d unw=%0d valid=%0d want %0d %0d %0d", k,
                 q_freq[k], q_unw[k], q_val[k], (100 * (k + 1)) / 16, 100 * (k + 1), (k == 15) ? 1 : 0);
      end
    end
  endtask

  task automatic test_clear();
    do_clear(); flush();
    for (int k = 0; k < 10; k++) send(100 * k);
    clear        = 1'b1;
    phase_in     = 1000;
    input_strobe = 1'b1;
    @(posedge clock); #1;
    clear        = 1'b0;
    input_strobe = 1'b0;
    checks++;
    if (freq_valid !== 1'b0 || phase_unwrapped !== 32'sd0 || freq_out !== 32'sd0) begin
      errors++;
      $display("FAIL clear_state got valid=%b unw=%0d freq=%0d want 0 0 0", freq_valid, phase_unwrapped, freq_out);
    end
    idle(6); flush();
    send(2000);
    idle(6);
    checks++;
    if (q_freq.size() !== 0) begin
      errors++;
      $display("FAIL clear_first_silent got %0d outputs want 0", q_freq.size());
    end
    send(2050);
    idle(6);
    checks++;
    if (q_freq.size() !== 1 || q_freq[0] !== 3 || q_unw[0] !== 2050 || q_val[0] !== 0) begin
      errors++;
      $display("FAIL clear_second got n=%0d freq=%0d unw=%0d valid=%0d want 1 3 2050 0",
               q_freq.size(), q_freq[0], q_unw[0], q_val[0]);
    end
  endtask

  task automatic test_async_reset();
    int n_before;
    do_clear(); flush();
    for (int k = 0; k < 5; k++) send(100 * k);
    input_strobe = 1'b0;
    #2;
    checks++;
    if (freq_out !== 32'sd12 || phase_unwrapped !== 32'sd200) begin
      errors++;
      $display("FAIL pre_reset got freq=%0d unw=%0d want 12 200", freq_out, phase_unwrapped);
    end
    n_before = q_freq.size();
    reset = 1'b1;
    #1;
    checks++;
    if (freq_out !== 32'sd0 || phase_unwrapped !== 32'sd0 || freq_valid !== 1'b0 || output_strobe !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got freq=%0d unw=%0d valid=%b strobe=%b want 0 0 0 0",
               freq_out, phase_unwrapped, freq_valid, output_strobe);
    end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    idle(8);
    checks++;
    if (q_freq.size() !== n_before) begin
      errors++;
      $display("FAIL reset_discard got %0d outputs want %0d", q_freq.size(), n_before);
    end
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    clear        = 1'b0;
    input_strobe = 1'b0;
    phase_in     = 32'sd0;
    test_reset();
    test_ramp();
    test_wrap();
    test_negative_floor();
    test_enable_gap();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
